// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for seq_divider.
// Carries the dbz flag only when SEQ_DIVIDER_DBZ_FLAG_EN is defined.
interface seq_divider_if #(
   parameter int WIDTH = 4
) ();
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;
   logic             busy;
   logic             done;
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
   logic             dbz;

   modport master (output start, a, b, input q, r, busy, done, dbz);
   modport slave  (input start, a, b, output q, r, busy, done, dbz);
`else
   modport master (output start, a, b, input q, r, busy, done);
   modport slave  (input start, a, b, output q, r, busy, done);
`endif
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional divide-by-zero flag output enabled by SEQ_DIVIDER_DBZ_FLAG_EN.
//
// state | meaning
// IDLE  | waiting for start; q/r hold last result
// RUN   | WIDTH shift/compare/subtract steps
// DONE  | one cycle: publish q/r and pulse done
module seq_divider #(
   parameter int WIDTH = 4
) (
   input logic        clk,
   input logic        rst,
   seq_divider_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] part_q, part_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             done_q, done_d;
   logic [WIDTH:0]   shifted;
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
   logic             dbz_q, dbz_d;
`endif

   // After each restore step the partial remainder is below the divisor, so
   // only WIDTH bits need storing; the extra bit lives in the shifted value.
   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      part_d  = part_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      r_d     = r_q;
      done_d  = 1'b0;
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
      dbz_d   = dbz_q;
`endif
      shifted = {part_q, dvd_q[WIDTH-1]};
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               dvd_d   = bus.a;
               dvs_d   = bus.b;
               part_d  = '0;
               quo_d   = '0;
               cnt_d   = CW'(WIDTH);
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
            if (shifted >= {1'b0, dvs_q}) begin
               part_d = WIDTH'(shifted - {1'b0, dvs_q});
               quo_d  = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               part_d = WIDTH'(shifted);
               quo_d  = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = S_DONE;
         end
         S_DONE: begin
            q_d     = quo_q;
            r_d     = part_q;
            done_d  = 1'b1;
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
            dbz_d   = (dvs_q == '0);
`endif
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         dvd_q   <= '0;
         dvs_q   <= '0;
         part_q  <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         done_q  <= 1'b0;
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
         dbz_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         part_q  <= part_d;
         quo_q   <= quo_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         r_q     <= r_d;
         done_q  <= done_d;
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
         dbz_q   <= dbz_d;
`endif
      end
   end

   assign bus.q    = q_q;
   assign bus.r    = r_q;
   assign bus.done = done_q;
   assign bus.busy = (state_q != S_IDLE);
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
   assign bus.dbz  = dbz_q;
`endif
endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider at WIDTH=4.
// Checks the dbz flag as well when SEQ_DIVIDER_DBZ_FLAG_EN is defined.
module tb_seq_divider;
   localparam int W = 4;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_fail;

   seq_divider_if #(.WIDTH(W)) bus ();

   seq_divider #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one request and wait (bounded) for done; latency counts edges after the accept edge.
   task automatic do_div(input logic [W-1:0] av, input logic [W-1:0] bv,
                         output logic [W-1:0] oq, output logic [W-1:0] orr,
                         output int lat, output int busy_cyc);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = av;
      bus.b     = bv;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat       = 0;
      busy_cyc  = bus.busy ? 1 : 0;
      while (!bus.done && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.busy) busy_cyc++;
      end
      oq  = bus.q;
      orr = bus.r;
   endtask

   task automatic test_reset();
      rst_n     = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      #3 rst_n  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (bus.q !== 4'd0)  begin n_fail++; $display("FAIL reset_q got %0d want 0", bus.q); end
      n_cmp++; if (bus.r !== 4'd0)  begin n_fail++; $display("FAIL reset_r got %0d want 0", bus.r); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
      n_cmp++; if (bus.dbz !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got %b want 0", bus.dbz); end
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic [W-1:0] oq, orr;
      int lat, bc;
      do_div(4'd6, 4'd2, oq, orr, lat, bc);
      n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL basic_latency got %0d want 5", lat); end
      n_cmp++; if (bc !== 5)  begin n_fail++; $display("FAIL basic_busy_cycles got %0d want 5", bc); end
      n_cmp++; if (oq !== 4'd3) begin n_fail++; $display("FAIL basic_q got %0d want 3", oq); end
      n_cmp++; if (orr !== 4'd0) begin n_fail++; $display("FAIL basic_r got %0d want 0", orr); end
      @(posedge clk);
      #1;
      n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width got %b want 0", bus.done); end
      n_cmp++; if (bus.q !== 4'd3) begin n_fail++; $display("FAIL basic_q_hold got %0d want 3", bus.q); end
   endtask

   task automatic test_vectors();
      logic [W-1:0] va [4] = '{4'd15, 4'd15, 4'd0, 4'd5};
      logic [W-1:0] vb [4] = '{4'd4,  4'd15, 4'd7, 4'd9};
      logic [W-1:0] eq [4] = '{4'd3,  4'd1,  4'd0, 4'd0};
      logic [W-1:0] er [4] = '{4'd3,  4'd0,  4'd0, 4'd5};
      logic [W-1:0] oq, orr;
      int lat, bc;
      for (int i = 0; i < 4; i++) begin
         do_div(va[i], vb[i], oq, orr, lat, bc);
         n_cmp++; if (oq !== eq[i]) begin n_fail++; $display("FAIL vec%0d_q %0d/%0d got %0d want %0d", i, va[i], vb[i], oq, eq[i]); end
         n_cmp++; if (orr !== er[i]) begin n_fail++; $display("FAIL vec%0d_r %0d/%0d got %0d want %0d", i, va[i], vb[i], orr, er[i]); end
         n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL vec%0d_latency got %0d want 5", i, lat); end
      end
   endtask

   task automatic test_div_zero();
      logic [W-1:0] oq, orr;
      int lat, bc;
      do_div(4'd5, 4'd0, oq, orr, lat, bc);
      n_cmp++; if (oq !== 4'd15) begin n_fail++; $display("FAIL dbz_q got %0d want 15", oq); end
      n_cmp++; if (orr !== 4'd5) begin n_fail++; $display("FAIL dbz_r got %0d want 5", orr); end
      n_cmp++; if (lat !== 5)    begin n_fail++; $display("FAIL dbz_latency got %0d want 5", lat); end
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
      n_cmp++; if (bus.dbz !== 1'b1) begin n_fail++; $display("FAIL dbz_flag got %b want 1", bus.dbz); end
`endif
      do_div(4'd10, 4'd2, oq, orr, lat, bc);
      n_cmp++; if (oq !== 4'd5)  begin n_fail++; $display("FAIL after_dbz_q got %0d want 5", oq); end
      n_cmp++; if (orr !== 4'd0) begin n_fail++; $display("FAIL after_dbz_r got %0d want 0", orr); end
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
      n_cmp++; if (bus.dbz !== 1'b0) begin n_fail++; $display("FAIL after_dbz_flag got %b want 0", bus.dbz); end
`endif
   endtask

   task automatic test_start_while_busy();
      int dones = 0;
      int first_done = -1;
      logic [W-1:0] got_q = '1, got_r = '1;
      @(negedge clk);
      bus.start = 1'b1; bus.a = 4'd12; bus.b = 4'd5;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int e = 1; e <= 15; e++) begin
         @(posedge clk); #1;
         if (e == 2) begin bus.start = 1'b1; bus.a = 4'd15; bus.b = 4'd1; end
         if (e == 3) begin bus.start = 1'b0; bus.a = 4'd3;  bus.b = 4'd7; end
         if (bus.done) begin
            dones++;
            if (first_done < 0) first_done = e;
            got_q = bus.q; got_r = bus.r;
         end
      end
      n_cmp++; if (dones !== 1) begin n_fail++; $display("FAIL busy_ignore_done_count got %0d want 1", dones); end
      n_cmp++; if (first_done !== 5) begin n_fail++; $display("FAIL busy_ignore_latency got %0d want 5", first_done); end
      n_cmp++; if (got_q !== 4'd2) begin n_fail++; $display("FAIL busy_ignore_q got %0d want 2", got_q); end
      n_cmp++; if (got_r !== 4'd2) begin n_fail++; $display("FAIL busy_ignore_r got %0d want 2", got_r); end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] oq, orr;
      int lat, bc;
      int dones = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.a = 4'd14; bus.b = 4'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.q !== 4'd0)    begin n_fail++; $display("FAIL midrst_q got %0d want 0", bus.q); end
      n_cmp++; if (bus.r !== 4'd0)    begin n_fail++; $display("FAIL midrst_r got %0d want 0", bus.r); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 0; e < 8; e++) begin
         @(posedge clk); #1;
         if (bus.done) dones++;
      end
      n_cmp++; if (dones !== 0) begin n_fail++; $display("FAIL midrst_done_count got %0d want 0", dones); end
      do_div(4'd14, 4'd3, oq, orr, lat, bc);
      n_cmp++; if (oq !== 4'd4)  begin n_fail++; $display("FAIL midrst_retry_q got %0d want 4", oq); end
      n_cmp++; if (orr !== 4'd2) begin n_fail++; $display("FAIL midrst_retry_r got %0d want 2", orr); end
   endtask

   task automatic test_back_to_back();
      int dones = 0;
      int last = -1;
      @(negedge clk);
      bus.start = 1'b1; bus.a = 4'd9; bus.b = 4'd2;
      for (int e = 0; e < 20; e++) begin
         @(posedge clk); #1;
         if (bus.done) begin
            dones++;
            n_cmp++; if (bus.q !== 4'd4) begin n_fail++; $display("FAIL b2b_q pulse %0d got %0d want 4", dones, bus.q); end
            n_cmp++; if (bus.r !== 4'd1) begin n_fail++; $display("FAIL b2b_r pulse %0d got %0d want 1", dones, bus.r); end
            if (last >= 0) begin
               n_cmp++; if (e - last !== 6) begin n_fail++; $display("FAIL b2b_spacing got %0d want 6", e - last); end
            end
            last = e;
         end
      end
      bus.start = 1'b0;
      n_cmp++; if (dones !== 3) begin n_fail++; $display("FAIL b2b_done_count got %0d want 3", dones); end
      repeat (8) @(posedge clk);
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      test_reset();
      test_basic();
      test_vectors();
      test_div_zero();
      test_start_while_busy();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
